io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder.sv | 125 ++++++++++++
 tb/tb_io_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// Byte-wide I/O responder: a host-to-CPU input FIFO and a CPU-to-host output FIFO,
// with sticky underflow/overflow flags for CPU accesses that could not be honoured.
module io_responder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IEnable,
    output logic [7:0]                 I,
    input  logic                       OEnable,
    input  logic [7:0]                 O,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     in_level,
    output logic [$clog2(DEPTH):0]     out_level,
    output logic                       underflow,
    output logic                       overflow,
    input  logic                       clear_flags
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    in_mem_q  [DEPTH];
    logic [AW-1:0] in_wp_q, in_rp_q;
    logic [LW-1:0] in_level_q;

    logic [7:0]    out_mem_q [DEPTH];
    logic [AW-1:0] out_wp_q, out_rp_q;
    logic [LW-1:0] out_level_q;

    logic underflow_q, overflow_q;

    logic in_push, in_pop, in_empty;
    logic out_push, out_pop, out_full;
    logic underflow_set, overflow_set;

    always_comb begin
        in_empty      = (in_level_q == '0);
        in_ready      = (in_level_q < LW'(DEPTH));
        in_push       = in_valid & in_ready;
        in_pop        = IEnable & ~in_empty;
        underflow_set = IEnable & in_empty;

        out_valid     = (out_level_q != '0);
        out_full      = (out_level_q == LW'(DEPTH));
        out_pop       = out_valid & out_ready;
        // A full FIFO still takes a write when the host frees a slot on the same edge.
        out_push      = OEnable & (~out_full | out_pop);
        overflow_set  = OEnable & out_full & ~out_pop;

        I         = in_empty ? 8'h00 : in_mem_q[in_rp_q];
        out_data  = out_valid ? out_mem_q[out_rp_q] : 8'h00;
        in_level  = in_level_q;
        out_level = out_level_q;
        underflow = underflow_q;
        overflow  = overflow_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                in_mem_q[i] <= 8'h00;
            end
            in_wp_q    <= '0;
            in_rp_q    <= '0;
            in_level_q <= '0;
        end else begin
            if (in_push) begin
                in_mem_q[in_wp_q] <= in_data;
                in_wp_q           <= in_wp_q + AW'(1);
            end
            if (in_pop) begin
                in_rp_q <= in_rp_q + AW'(1);
            end
            case ({in_push, in_pop})
                2'b10:   in_level_q <= in_level_q + LW'(1);
                2'b01:   in_level_q <= in_level_q - LW'(1);
                default: in_level_q <= in_level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                out_mem_q[i] <= 8'h00;
            end
            out_wp_q    <= '0;
            out_rp_q    <= '0;
            out_level_q <= '0;
        end else begin
            if (out_push) begin
                out_mem_q[out_wp_q] <= O;
                out_wp_q            <= out_wp_q + AW'(1);
            end
            if (out_pop) begin
                out_rp_q <= out_rp_q + AW'(1);
            end
            case ({out_push, out_pop})
                2'b10:   out_level_q <= out_level_q + LW'(1);
                2'b01:   out_level_q <= out_level_q - LW'(1);
                default: out_level_q <= out_level_q;
            endcase
        end
    end

    // Set events take priority over a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (underflow_set)    underflow_q <= 1'b1;
            else if (clear_flags) underflow_q <= 1'b0;
            if (overflow_set)     overflow_q  <= 1'b1;
            else if (clear_flags) overflow_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: scoreboard queues model both FIFOs.
module tb_io_responder;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          IEnable, OEnable, in_valid, out_ready, clear_flags;
    logic [7:0]    I, O, in_data, out_data;
    logic          in_ready, out_valid, underflow, overflow;
    logic [LW-1:0] in_level, out_level;

    int checks = 0;
    int errors = 0;
    logic [7:0] in_sb[$];
    logic [7:0] out_sb[$];
    logic [7:0] exp_b;

    io_responder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .IEnable(IEnable), .I(I), .OEnable(OEnable), .O(O),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_level(in_level), .out_level(out_level), .underflow(underflow),
        .overflow(overflow), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    task automatic idle();
        IEnable = 0; OEnable = 0; O = 0; in_valid = 0; in_data = 0;
        out_ready = 0; clear_flags = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        #1;
        checks++; if (I !== 8'h00) begin errors++; $display("FAIL reset_I got %0h exp 00", I); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h exp 00", out_data); end
        checks++; if (in_level !== 0 || out_level !== 0) begin errors++; $display("FAIL reset_levels got %0d/%0d exp 0/0", in_level, out_level); end
        checks++; if (underflow !== 0 || overflow !== 0) begin errors++; $display("FAIL reset_flags got %0b/%0b exp 0/0", underflow, overflow); end
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_input_basic();
        in_valid = 1; in_data = 8'h11; in_sb.push_back(8'h11);
        @(negedge clk);
        in_data = 8'h22; in_sb.push_back(8'h22);
        @(negedge clk);
        in_valid = 0;
        checks++; if (in_level !== LW'(in_sb.size())) begin errors++; $display("FAIL basic_level2 got %0d exp %0d", in_level, in_sb.size()); end
        for (int k = 0; k < 2; k++) begin
            exp_b = in_sb.pop_front();
            checks++; if (I !== exp_b) begin errors++; $display("FAIL basic_I got %0h exp %0h", I, exp_b); end
            IEnable = 1;
            @(negedge clk);
            IEnable = 0;
            checks++; if (in_level !== LW'(in_sb.size())) begin errors++; $display("FAIL basic_level got %0d exp %0d", in_level, in_sb.size()); end
        end
        checks++; if (I !== 8'h00) begin errors++; $display("FAIL basic_I_empty got %0h exp 00", I); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL basic_underflow got %0b exp 0", underflow); end
    endtask

    task automatic test_underflow();
        IEnable = 1;
        @(negedge clk);
        IEnable = 0;
        checks++; if (I !== 8'h00 || underflow !== 1'b1) begin errors++; $display("FAIL uf_set got I=%0h uf=%0b exp 00/1", I, underflow); end
        clear_flags = 1;
        @(negedge clk);
        clear_flags = 0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %0b exp 0", underflow); end
        IEnable = 1; clear_flags = 1;
        @(negedge clk);
        IEnable = 0; clear_flags = 0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins got %0b exp 1", underflow); end
        // Empty read plus same-edge push: push accepted, no bypass, pointers intact.
        IEnable = 1; in_valid = 1; in_data = 8'h5A; in_sb.push_back(8'h5A); clear_flags = 1;
        @(negedge clk);
        IEnable = 0; in_valid = 0; clear_flags = 0;
        checks++; if (in_level !== 1 || I !== in_sb[0]) begin errors++; $display("FAIL uf_push got lvl=%0d I=%0h exp 1/%0h", in_level, I, in_sb[0]); end
        IEnable = 1; void'(in_sb.pop_front()); clear_flags = 1;
        @(negedge clk);
        IEnable = 0; clear_flags = 0;
        checks++; if (in_level !== 0 || underflow !== 0) begin errors++; $display("FAIL uf_drain got lvl=%0d uf=%0b exp 0/0", in_level, underflow); end
    endtask

    task automatic drain_out(input string name);
        out_ready = 1;
        while (out_sb.size() > 0) begin
            exp_b = out_sb.pop_front();
            checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin errors++; $display("FAIL %s got v=%0b d=%0h exp 1/%0h", name, out_valid, out_data, exp_b); end
            @(negedge clk);
        end
        out_ready = 0;
        checks++; if (out_valid !== 0 || out_level !== 0) begin errors++; $display("FAIL %s_empty got v=%0b lvl=%0d exp 0/0", name, out_valid, out_level); end
    endtask

    task automatic test_overflow();
        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            OEnable = 1; O = 8'hA0 + 8'(k);
            if (k < DEPTH) out_sb.push_back(O);
            @(negedge clk);
        end
        OEnable = 0;
        checks++; if (out_level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level got %0d exp %0d", out_level, DEPTH); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        drain_out("ovf_drain");
        clear_flags = 1;
        @(negedge clk);
        clear_flags = 0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
    endtask

    task automatic test_full_passthrough();
        for (int k = 0; k < DEPTH; k++) begin
            OEnable = 1; O = 8'hB0 + 8'(k); out_sb.push_back(O);
            @(negedge clk);
        end
        OEnable = 1; O = 8'h55; out_ready = 1;
        void'(out_sb.pop_front()); out_sb.push_back(8'h55);
        @(negedge clk);
        OEnable = 0; out_ready = 0;
        checks++; if (out_level !== LW'(DEPTH)) begin errors++; $display("FAIL pass_level got %0d exp %0d", out_level, DEPTH); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pass_ovf got %0b exp 0", overflow); end
        drain_out("pass_drain");
    endtask

    task automatic test_wrap();
        for (int k = 1; k <= DEPTH; k++) begin
            in_valid = 1; in_data = 8'(k); in_sb.push_back(in_data);
            @(negedge clk);
        end
        in_valid = 0;
        checks++; if (in_ready !== 1'b0 || in_level !== LW'(DEPTH)) begin errors++; $display("FAIL wrap_full got rdy=%0b lvl=%0d exp 0/%0d", in_ready, in_level, DEPTH); end
        // Offer a byte while full: must not be taken.
        in_valid = 1; in_data = 8'hEE;
        @(negedge clk);
        in_valid = 0;
        checks++; if (in_level !== LW'(DEPTH)) begin errors++; $display("FAIL wrap_nopush got %0d exp %0d", in_level, DEPTH); end
        exp_b = in_sb.pop_front();
        checks++; if (I !== exp_b) begin errors++; $display("FAIL wrap_I got %0h exp %0h", I, exp_b); end
        IEnable = 1;
        @(negedge clk);
        for (int k = DEPTH + 1; k <= DEPTH + 6; k++) begin
            exp_b = in_sb.pop_front();
            checks++; if (I !== exp_b) begin errors++; $display("FAIL wrap_I got %0h exp %0h", I, exp_b); end
            in_valid = 1; in_data = 8'(k); in_sb.push_back(in_data);
            @(negedge clk);
            checks++; if (in_level !== LW'(in_sb.size())) begin errors++; $display("FAIL wrap_level got %0d exp %0d", in_level, in_sb.size()); end
        end
        in_valid = 0;
        while (in_sb.size() > 0) begin
            exp_b = in_sb.pop_front();
            checks++; if (I !== exp_b) begin errors++; $display("FAIL wrap_drain got %0h exp %0h", I, exp_b); end
            @(negedge clk);
        end
        IEnable = 0;
        checks++; if (in_level !== 0 || underflow !== 0) begin errors++; $display("FAIL wrap_end got lvl=%0d uf=%0b exp 0/0", in_level, underflow); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_data = 8'hC0 + 8'(k);
            OEnable = 1; O = 8'hD0 + 8'(k);
            @(negedge clk);
        end
        OEnable = 1; O = 8'hFF; out_ready = 0;
        checks++; if (in_level !== 2 || out_level !== 2) begin errors++; $display("FAIL ar_pre got %0d/%0d exp 2/2", in_level, out_level); end
        #2 rst = 0;
        #1;
        checks++; if (in_level !== 0 || out_level !== 0) begin errors++; $display("FAIL ar_levels got %0d/%0d exp 0/0", in_level, out_level); end
        checks++; if (I !== 8'h00 || out_valid !== 0 || in_ready !== 1 || out_data !== 8'h00) begin errors++; $display("FAIL ar_outputs got I=%0h ov=%0b ir=%0b od=%0h exp 00/0/1/00", I, out_valid, in_ready, out_data); end
        @(negedge clk);
        checks++; if (in_level !== 0 || out_level !== 0) begin errors++; $display("FAIL ar_hold got %0d/%0d exp 0/0", in_level, out_level); end
        idle();
        rst = 1;
        @(negedge clk);
        checks++; if (I !== 8'h00 || out_valid !== 0) begin errors++; $display("FAIL ar_after got I=%0h ov=%0b exp 00/0", I, out_valid); end
    endtask

    initial begin
        test_reset();
        test_input_basic();
        test_underflow();
        test_overflow();
        test_full_passthrough();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
